// File: rtl/timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_if
// Bundle between the button debouncers / display multiplexer and the
// time-of-day controller.
//   btn_mode, btn_inc, btn_clr : single-cycle debounced button pulses
//   scan_clken                 : one-cycle enable for the display multiplexer
//   mode                       : 0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC
//   sec0..hr1                  : active-low segment patterns {dp,g,f,e,d,c,b,a}
// Modports:
//   master : the side that issues button pulses and consumes the display signals
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface timer_ctrl_if;
   logic       btn_mode;
   logic       btn_inc;
   logic       btn_clr;
   logic       scan_clken;
   logic [1:0] mode;
   logic [7:0] sec0;
   logic [7:0] sec1;
   logic [7:0] min0;
   logic [7:0] min1;
   logic [7:0] hr0;
   logic [7:0] hr1;

   modport master (
      output btn_mode, btn_inc, btn_clr,
      input  scan_clken, mode, sec0, sec1, min0, min1, hr0, hr1
   );

   modport slave (
      input  btn_mode, btn_inc, btn_clr,
      output scan_clken, mode, sec0, sec1, min0, min1, hr0, hr1
   );
endinterface

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// 24-hour HH:MM:SS time-of-day keeper in BCD with a button-driven set mode,
// producing six active-low 7-segment digit patterns and the scan enable pulse
// for the display multiplexer.
// Ports:
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   bus   : timer_ctrl_if.slave (button pulses in; scan_clken, mode, digits out)
// Parameters:
//   SEC_DIV   : clk cycles per 1 s tick
//   SCAN_DIV  : clk cycles per scan_clken pulse
//   BLINK_DIV : clk cycles per blink-phase toggle
// -----------------------------------------------------------------------------
module timer_ctrl #(
   parameter int SEC_DIV   = 100_000_000,
   parameter int SCAN_DIV  = 100_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic        clk,
   input  logic        rstn,
   timer_ctrl_if.slave bus
);

   localparam int SEC_W   = $clog2(SEC_DIV);
   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);

   localparam logic [SEC_W-1:0]   SEC_MAX   = SEC_W'(SEC_DIV - 1);
   localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } state_t;

   state_t              state_reg;
   logic [SEC_W-1:0]    sec_cnt_reg, sec_cnt_next;
   logic [SCAN_W-1:0]   scan_cnt_reg, scan_cnt_next;
   logic                scan_clken_reg;
   logic [BLINK_W-1:0]  blink_cnt_reg;
   logic                blink_hidden_reg;
   // Digit order: 0=sec units, 1=sec tens, 2=min units, 3=min tens, 4=hr units, 5=hr tens.
   logic [5:0][3:0]     digit_reg, digit_next;

   logic                clr_acc;
   logic                mode_acc;
   logic                inc_acc;
   logic                tick;
   logic [1:0]          edit_field;
   logic [7:0]          seg [6];

   // Button priority: clr > mode > inc. Increment only has an effect while editing.
   assign clr_acc  = bus.btn_clr;
   assign mode_acc = bus.btn_mode & ~bus.btn_clr;
   assign inc_acc  = bus.btn_inc & ~bus.btn_clr & ~bus.btn_mode & (state_reg != RUN);

   // A button acting in RUN (clr or mode) swallows the tick of that cycle.
   assign tick = (state_reg == RUN) && (sec_cnt_reg == SEC_MAX) && !bus.btn_clr && !bus.btn_mode;

   // BCD +1 for a 00..59 field, wrapping to 00.
   function automatic logic [7:0] inc_bcd59(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] != 4'd9)
         r = {v[7:4], v[3:0] + 4'd1};
      else if (v[7:4] != 4'd5)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = 8'h00;
      return r;
   endfunction

   // BCD +1 for the 00..23 hour field, wrapping to 00.
   function automatic logic [7:0] inc_bcd23(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h23)
         r = 8'h00;
      else if (v[3:0] != 4'd9)
         r = {v[7:4], v[3:0] + 4'd1};
      else
         r = {v[7:4] + 4'd1, 4'd0};
      return r;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= RUN;
      end else if (mode_acc) begin
         case (state_reg)
            RUN:     state_reg <= SET_HR;
            SET_HR:  state_reg <= SET_MIN;
            SET_MIN: state_reg <= SET_SEC;
            default: state_reg <= RUN;
         endcase
      end
   end

   // ---------------------------------------------------------------- scan prescaler
   always_comb begin
      scan_cnt_next = (scan_cnt_reg == SCAN_MAX) ? '0 : scan_cnt_reg + 1'b1;
   end

   // Registered so the pulse lines up with the counter sitting at its last value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scan_cnt_reg   <= '0;
         scan_clken_reg <= 1'b0;
      end else begin
         scan_cnt_reg   <= scan_cnt_next;
         scan_clken_reg <= (scan_cnt_next == SCAN_MAX);
      end
   end

   // ---------------------------------------------------------------- second prescaler
   always_comb begin
      if (clr_acc || state_reg != RUN)
         sec_cnt_next = '0;
      else if (mode_acc)
         sec_cnt_next = sec_cnt_reg;          // held, not skipped
      else if (sec_cnt_reg == SEC_MAX)
         sec_cnt_next = '0;
      else
         sec_cnt_next = sec_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         sec_cnt_reg <= '0;
      else
         sec_cnt_reg <= sec_cnt_next;
   end

   // ---------------------------------------------------------------- time of day
   always_comb begin
      digit_next = digit_reg;
      if (clr_acc) begin
         digit_next = '0;
      end else if (tick) begin
         digit_next[1:0] = inc_bcd59(digit_reg[1:0]);
         if (digit_reg[1:0] == 8'h59) begin
            digit_next[3:2] = inc_bcd59(digit_reg[3:2]);
            if (digit_reg[3:2] == 8'h59)
               digit_next[5:4] = inc_bcd23(digit_reg[5:4]);
         end
      end else if (inc_acc) begin
         // Editing never carries into neighbouring fields.
         case (state_reg)
            SET_HR:  digit_next[5:4] = inc_bcd23(digit_reg[5:4]);
            SET_MIN: digit_next[3:2] = inc_bcd59(digit_reg[3:2]);
            SET_SEC: digit_next[1:0] = inc_bcd59(digit_reg[1:0]);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         digit_reg <= '0;
      else
         digit_reg <= digit_next;
   end

   // ---------------------------------------------------------------- blink phase
   // Restarting on every accepted edit keeps the field visible right after a press.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blink_cnt_reg    <= '0;
         blink_hidden_reg <= 1'b0;
      end else if (mode_acc || inc_acc) begin
         blink_cnt_reg    <= '0;
         blink_hidden_reg <= 1'b0;
      end else if (blink_cnt_reg == BLINK_MAX) begin
         blink_cnt_reg    <= '0;
         blink_hidden_reg <= ~blink_hidden_reg;
      end else begin
         blink_cnt_reg    <= blink_cnt_reg + 1'b1;
      end
   end

   // ---------------------------------------------------------------- digit outputs
   // Field being edited: 0=sec, 1=min, 2=hr; 3 matches no digit, so RUN never blanks.
   always_comb begin
      case (state_reg)
         SET_HR:  edit_field = 2'd2;
         SET_MIN: edit_field = 2'd1;
         SET_SEC: edit_field = 2'd0;
         default: edit_field = 2'd3;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_digit
         localparam logic [1:0] FIELD = 2'(gi / 2);
         assign seg[gi] = (blink_hidden_reg && edit_field == FIELD) ? 8'hFF
                                                                    : seg_decode(digit_reg[gi]);
      end
   endgenerate

   assign bus.sec0       = seg[0];
   assign bus.sec1       = seg[1];
   assign bus.min0       = seg[2];
   assign bus.min1       = seg[3];
   assign bus.hr0        = seg[4];
   assign bus.hr1        = seg[5];
   assign bus.mode       = state_reg;
   assign bus.scan_clken = scan_clken_reg;

endmodule
